// File: rtl/video_frame_align_if.sv
// Handshake bundle for video_frame_align: the upstream buffer stream, the framed output stream,
// the frame geometry and the repair status pulses.
interface video_frame_align_if #(
  parameter int BITWIDTH = 32
);
  logic [BITWIDTH-1:0] sink_data;
  logic                sink_valid;
  logic                sink_sop;
  logic                sink_eop;
  logic                sink_ready;
  logic [BITWIDTH-1:0] source_data;
  logic                source_valid;
  logic                source_ready;
  logic                source_sop;
  logic                source_eop;
  logic                source_eol;
  logic [15:0]         width;
  logic [15:0]         height;
  logic [2:0]          err;

  modport master (
    output sink_data, sink_valid, sink_sop, sink_eop, source_ready, width, height,
    input  sink_ready, source_data, source_valid, source_sop, source_eop, source_eol, err
  );

  modport slave (
    input  sink_data, sink_valid, sink_sop, sink_eop, source_ready, width, height,
    output sink_ready, source_data, source_valid, source_sop, source_eop, source_eol, err
  );
endinterface

// File: rtl/video_frame_align.sv
// Re-frames a latency-1 pixel stream into exact width x height frames (pad / truncate / drop).
// Defining VIDEO_FRAME_ALIGN_XY_EN adds the x_pos/y_pos coordinate outputs.
module video_frame_align #(
  parameter int                  BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0] PAD_VALUE = '0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VIDEO_FRAME_ALIGN_XY_EN
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
`endif
  video_frame_align_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DISCARD} state_t;

  localparam int ENTRY_W = BITWIDTH + 2;

  logic [ENTRY_W-1:0]  r_mem [4];
  logic [1:0]          r_rd_ptr;
  logic [1:0]          r_wr_ptr;
  logic [2:0]          r_count;
  logic                r_req_d;
  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_x;
  logic [15:0]         r_y;
  logic [15:0]         r_wl;
  logic [15:0]         r_hl;

  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_head_sop;
  logic                w_head_eop;
  logic [BITWIDTH-1:0] w_head_data;
  logic                w_valid;
  logic                w_xfer;
  logic                w_latch;
  logic                w_x_last;
  logic                w_y_last;
  logic                w_first;
  logic [2:0]          w_err;

  assign w_empty = (r_count == 3'd0);
  assign w_push  = bus.sink_valid;
  assign {w_head_sop, w_head_eop, w_head_data} = r_mem[r_rd_ptr];

  // Beats already stored plus the one still in flight never exceed the 4 entries.
  assign bus.sink_ready = !rst && ((r_count + {2'b00, r_req_d}) <= 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_req_d  <= 1'b0;
    end else begin
      r_req_d <= bus.sink_ready;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {bus.sink_sop, bus.sink_eop, bus.sink_data};
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_x_last = (r_x == r_wl - 16'd1);
  assign w_y_last = (r_y == r_hl - 16'd1);
  assign w_first  = (r_x == 16'd0) && (r_y == 16'd0);
  assign w_xfer   = w_valid && bus.source_ready;

  // A sop arriving mid-frame is left in the buffer so it can open the next frame after padding.
  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    w_err        = 3'b000;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (!w_head_sop) begin
            w_pop    = 1'b1;
            w_err[2] = 1'b1;
          end else begin
            w_latch = 1'b1;
            if ((bus.width == 16'd0) || (bus.height == 16'd0)) begin
              w_pop        = 1'b1;
              w_err[2]     = 1'b1;
              w_state_next = DISCARD;
            end else begin
              w_state_next = ACTIVE;
            end
          end
        end
      end
      ACTIVE: begin
        if (!w_empty) begin
          if (w_head_sop && !w_first) begin
            w_err[0]     = 1'b1;
            w_state_next = PAD;
          end else begin
            w_valid = 1'b1;
            if (bus.source_ready) begin
              w_pop = 1'b1;
              if (w_x_last && w_y_last) begin
                if (w_head_eop) begin
                  w_state_next = IDLE;
                end else begin
                  w_err[1]     = 1'b1;
                  w_state_next = DISCARD;
                end
              end else if (w_head_eop) begin
                w_err[0]     = 1'b1;
                w_state_next = PAD;
              end
            end
          end
        end
      end
      PAD: begin
        w_valid = 1'b1;
        if (bus.source_ready && w_x_last && w_y_last) w_state_next = IDLE;
      end
      DISCARD: begin
        if (!w_empty) begin
          if (w_head_sop) begin
            w_state_next = IDLE;
          end else begin
            w_pop = 1'b1;
            if (w_head_eop) w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_wl    <= '0;
      r_hl    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_wl <= bus.width;
        r_hl <= bus.height;
        r_x  <= '0;
        r_y  <= '0;
      end else if (w_xfer) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? 16'd0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end

  // Markers are generated from the counters; the stored sop/eop bits never reach the output.
  assign bus.source_valid = w_valid;
  assign bus.source_data  = !w_valid ? '0 : ((r_state == PAD) ? PAD_VALUE : w_head_data);
  assign bus.source_sop   = w_valid && w_first;
  assign bus.source_eol   = w_valid && w_x_last;
  assign bus.source_eop   = w_valid && w_x_last && w_y_last;
  assign bus.err          = w_err;

`ifdef VIDEO_FRAME_ALIGN_XY_EN
  assign x_pos = r_x;
  assign y_pos = r_y;
`endif
endmodule

// File: tb/tb_video_frame_align.sv
// Self-checking bench for video_frame_align: table-driven frame cases, reset and backpressure
// sequences, and randomized streams compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_video_frame_align;
  localparam int             BW  = 32;
  localparam logic [BW-1:0]  PAD = 32'hA5A5_5A5A;

  typedef struct packed { logic sop; logic eop; logic [BW-1:0] data; } beatT;
  typedef struct packed { logic [BW-1:0] data; logic sop; logic eop; logic eol; } outT;
  typedef struct {
    int w; int h; int orphans; int nBeats; int eopAt;
    int expBeats; int expEopIdx; int expErr0; int expErr1; int expErr2;
  } caseT;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef VIDEO_FRAME_ALIGN_XY_EN
  logic [15:0] xPos;
  logic [15:0] yPos;
`endif

  video_frame_align_if #(.BITWIDTH(BW)) bus();

  video_frame_align #(.BITWIDTH(BW), .PAD_VALUE(PAD)) dut (
    .clk (clk),
    .rst (rst),
`ifdef VIDEO_FRAME_ALIGN_XY_EN
    .x_pos (xPos),
    .y_pos (yPos),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  beatT inQ[$];
  outT  expQ[$];
  int   expErr[3];
  int   obsErr[3];
  int   obsBeats;
  int   obsEopIdx;
  int   curW;
  int   curH;
  caseT cases[7];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void addBeat(input bit s, input bit e, input logic [BW-1:0] d);
    beatT b;
    b.sop  = s;
    b.eop  = e;
    b.data = d;
    inQ.push_back(b);
  endfunction

  function automatic void emitBeat(input int k, input logic [BW-1:0] d);
    outT o;
    o.data = d;
    o.sop  = (k == 0);
    o.eop  = (k == curW * curH - 1);
    o.eol  = ((k % curW) == curW - 1);
    expQ.push_back(o);
  endfunction

  // Frame-level model: walk the whole input list, cutting it into frames of curW*curH beats.
  function automatic void runModel();
    int i    = 0;
    int n    = inQ.size();
    int area = curW * curH;
    bit discard = 1'b0;
    expQ.delete();
    for (int e = 0; e < 3; e++) expErr[e] = 0;
    while (i < n) begin
      if (discard) begin
        if (inQ[i].sop) discard = 1'b0;
        else begin
          if (inQ[i].eop) discard = 1'b0;
          i++;
        end
      end else if (!inQ[i].sop) begin
        expErr[2]++;
        i++;
      end else if (area == 0) begin
        expErr[2]++;
        i++;
        discard = 1'b1;
      end else begin
        int k = 0;
        bit inFrame = 1'b1;
        while (inFrame && i < n) begin
          if (k > 0 && inQ[i].sop) begin
            for (int p = k; p < area; p++) emitBeat(p, PAD);
            expErr[0]++;
            inFrame = 1'b0;
          end else begin
            emitBeat(k, inQ[i].data);
            if (k == area - 1) begin
              if (!inQ[i].eop) begin
                expErr[1]++;
                discard = 1'b1;
              end
              inFrame = 1'b0;
            end else if (inQ[i].eop) begin
              for (int p = k + 1; p < area; p++) emitBeat(p, PAD);
              expErr[0]++;
              inFrame = 1'b0;
            end
            i++;
            k++;
          end
        end
      end
    end
  endfunction

  // readyMode: 0 = always ready, 1 = toggle every cycle, 2 = random.
  task automatic applyStimulus(input int readyMode, input bit gaps, input int maxCycles);
    int idx = 0;
    int quiet = 0;
    bit readyPrev = 1'b0;
    bit stallPrev = 1'b0;
    bit toggle = 1'b0;
    logic [BW+3:0] held = '0;
    logic [BW+3:0] now;
    outT got;
    outT want;
    obsBeats  = 0;
    obsEopIdx = -1;
    for (int e = 0; e < 3; e++) obsErr[e] = 0;
    for (int cyc = 0; cyc < maxCycles && quiet < 8; cyc++) begin
      @(negedge clk);
      if (readyPrev && idx < inQ.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
        bus.sink_valid = 1'b1;
        bus.sink_sop   = inQ[idx].sop;
        bus.sink_eop   = inQ[idx].eop;
        bus.sink_data  = inQ[idx].data;
        idx++;
      end else begin
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.sink_data  = $urandom;
      end
      readyPrev = bus.sink_ready;
      case (readyMode)
        0:       bus.source_ready = 1'b1;
        1: begin toggle = !toggle; bus.source_ready = toggle; end
        default: bus.source_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      now = {bus.source_valid, bus.source_data, bus.source_sop, bus.source_eop, bus.source_eol};
      if (stallPrev) checkOutput("stall hold", 64'(now), 64'(held));
      if (bus.source_valid && bus.source_ready) begin
        got.data = bus.source_data;
        got.sop  = bus.source_sop;
        got.eop  = bus.source_eop;
        got.eol  = bus.source_eol;
        checkOutput("beat expected", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
          want = expQ.pop_front();
          checkOutput($sformatf("beat %0d {data,sop,eop,eol}", obsBeats), 64'(got), 64'(want));
        end
        if (bus.source_eop) obsEopIdx = obsBeats;
        obsBeats++;
      end
      for (int e = 0; e < 3; e++) if (bus.err[e]) obsErr[e]++;
      stallPrev = bus.source_valid && !bus.source_ready;
      held = now;
      if (idx == inQ.size() && expQ.size() == 0) quiet++;
      else quiet = 0;
    end
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    checkOutput("stream consumed", 64'(idx), 64'(inQ.size()));
    checkOutput("expected drained", 64'(expQ.size()), 64'd0);
    for (int e = 0; e < 3; e++)
      checkOutput($sformatf("err[%0d] pulses", e), 64'(obsErr[e]), 64'(expErr[e]));
  endtask

  task automatic setGeometry(input int w, input int h);
    curW = w;
    curH = h;
    bus.width  = 16'(w);
    bus.height = 16'(h);
  endtask

  task automatic genRandom(input int nFrames);
    int area = curW * curH;
    int len;
    int orph;
    int kind;
    bit noEop;
    inQ.delete();
    for (int f = 0; f < nFrames; f++) begin
      orph = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      for (int o = 0; o < orph; o++) addBeat(1'b0, 1'b0, $urandom);
      kind = (f == nFrames - 1) ? 0 : $urandom_range(0, 9);
      if (kind <= 5)      len = area;
      else if (kind <= 7) len = $urandom_range(1, area);
      else                len = area + $urandom_range(1, 3);
      noEop = (f != nFrames - 1) && ($urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++) addBeat(k == 0, (k == len - 1) && !noEop, $urandom);
    end
  endtask

  task automatic cleanFrame(input logic [BW-1:0] base);
    inQ.delete();
    for (int k = 0; k < curW * curH; k++) addBeat(k == 0, k == curW * curH - 1, base + BW'(k));
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cases[0] = '{w:4, h:2, orphans:0, nBeats:8,  eopAt:7,  expBeats:8, expEopIdx:7,  expErr0:0, expErr1:0, expErr2:0};
    cases[1] = '{w:4, h:2, orphans:0, nBeats:5,  eopAt:4,  expBeats:8, expEopIdx:7,  expErr0:1, expErr1:0, expErr2:0};
    cases[2] = '{w:4, h:2, orphans:0, nBeats:11, eopAt:10, expBeats:8, expEopIdx:7,  expErr0:0, expErr1:1, expErr2:0};
    cases[3] = '{w:4, h:1, orphans:2, nBeats:4,  eopAt:3,  expBeats:4, expEopIdx:3,  expErr0:0, expErr1:0, expErr2:2};
    cases[4] = '{w:1, h:1, orphans:0, nBeats:1,  eopAt:0,  expBeats:1, expEopIdx:0,  expErr0:0, expErr1:0, expErr2:0};
    cases[5] = '{w:2, h:2, orphans:0, nBeats:1,  eopAt:0,  expBeats:4, expEopIdx:3,  expErr0:1, expErr1:0, expErr2:0};
    cases[6] = '{w:0, h:2, orphans:0, nBeats:3,  eopAt:2,  expBeats:0, expEopIdx:-1, expErr0:0, expErr1:0, expErr2:1};

    bus.sink_valid   = 1'b0;
    bus.sink_sop     = 1'b0;
    bus.sink_eop     = 1'b0;
    bus.sink_data    = '0;
    bus.source_ready = 1'b1;
    setGeometry(4, 2);

    // Reset state and first cycle after release.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset sink_ready", 64'(bus.sink_ready), 64'd0);
    checkOutput("reset outputs", 64'({bus.source_valid, bus.source_data, bus.source_sop,
                                     bus.source_eop, bus.source_eol, bus.err}), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("sink_ready after release", 64'(bus.sink_ready), 64'd1);

    // Table-driven frame cases.
    for (int c = 0; c < 7; c++) begin
      setGeometry(cases[c].w, cases[c].h);
      inQ.delete();
      for (int o = 0; o < cases[c].orphans; o++) addBeat(1'b0, 1'b0, 32'h0BAD_0000 + BW'(o));
      for (int k = 0; k < cases[c].nBeats; k++)
        addBeat(k == 0, k == cases[c].eopAt, 32'hC000_0000 + BW'(c * 256 + k));
      runModel();
      applyStimulus(0, 1'b0, 400);
      checkOutput($sformatf("case %0d beats", c), 64'(obsBeats), 64'(cases[c].expBeats));
      checkOutput($sformatf("case %0d eop index", c), 64'(obsEopIdx), 64'(cases[c].expEopIdx));
      checkOutput($sformatf("case %0d err0", c), 64'(obsErr[0]), 64'(cases[c].expErr0));
      checkOutput($sformatf("case %0d err1", c), 64'(obsErr[1]), 64'(cases[c].expErr1));
      checkOutput($sformatf("case %0d err2", c), 64'(obsErr[2]), 64'(cases[c].expErr2));
    end

    // Backpressure: source_ready toggling during a 4x2 frame with upstream gaps.
    setGeometry(4, 2);
    cleanFrame(32'h5000_0000);
    runModel();
    applyStimulus(1, 1'b1, 400);
    checkOutput("backpressure beats", 64'(obsBeats), 64'd8);
    checkOutput("backpressure eop index", 64'(obsEopIdx), 64'd7);

    // Reset mid-frame after 3 of 8 beats, then a fresh frame.
    begin
      int sent = 0;
      bit readyPrev = 1'b0;
      for (int cyc = 0; cyc < 50 && sent < 3; cyc++) begin
        @(negedge clk);
        if (readyPrev) begin
          bus.sink_valid = 1'b1;
          bus.sink_sop   = (sent == 0);
          bus.sink_eop   = 1'b0;
          bus.sink_data  = 32'h7700_0000 + BW'(sent);
          sent++;
        end else begin
          bus.sink_valid = 1'b0;
        end
        readyPrev = bus.sink_ready;
      end
      @(negedge clk);
      bus.sink_valid = 1'b0;
      bus.sink_sop   = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        #1;
        checkOutput($sformatf("mid-frame reset outputs %0d", r),
                    64'({bus.sink_ready, bus.source_valid, bus.source_data, bus.source_sop,
                         bus.source_eop, bus.source_eol, bus.err}), 64'd0);
      end
      rst = 1'b0;
      cleanFrame(32'h6000_0000);
      runModel();
      applyStimulus(0, 1'b1, 400);
      checkOutput("post-reset beats", 64'(obsBeats), 64'd8);
      checkOutput("post-reset err total", 64'(obsErr[0] + obsErr[1] + obsErr[2]), 64'd0);
    end

    // Randomized streams against the model, several geometries.
    for (int g = 0; g < 4; g++) begin
      case (g)
        0:       setGeometry(4, 2);
        1:       setGeometry(1, 1);
        2:       setGeometry(3, 3);
        default: setGeometry(2, 1);
      endcase
      genRandom(12);
      runModel();
      applyStimulus(2, 1'b1, 6000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_frame_align.md
# video_frame_align

Downstream stage for the video input packet buffer. It accepts the buffer's registered-valid pixel stream, which has a read latency of one cycle, and re-emits it as a clean frame of exactly width × height beats. Frame markers on the output come from its own pixel counters. Short frames are padded, long frames are truncated, and orphan beats outside a frame are discarded; each repair raises a status pulse for the flow monitor and debug logic.

## Interface
- BITWIDTH, 32, pixel data width
- PAD_VALUE, 0, data value emitted for padded beats (BITWIDTH bits)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- sink_data  in  BITWIDTH  pixel from upstream buffer
- sink_valid  in  1  beat present; only asserted the cycle after a cycle with sink_ready=1
- sink_sop  in  1  upstream start-of-frame marker
- sink_eop  in  1  upstream end-of-frame marker
- sink_ready  out  1  read request to upstream; read latency 1
- source_data  out  BITWIDTH  output pixel
- source_valid  out  1  output beat present
- source_ready  in  1  downstream accept; ready latency 0
- source_sop  out  1  first beat of frame (x=0, y=0)
- source_eop  out  1  last beat of frame (x=width-1, y=height-1)
- source_eol  out  1  last beat of each line
- width, height  in  16 each  frame geometry; sampled on the accepted sop beat
- err  out  3  one-cycle pulses: [0] short frame padded, [1] long frame truncated, [2] orphan/zero-size beat dropped

## Operation
- Input buffer
  - 4-entry FIFO built from registers; it stores {sop, eop, data}.
  - req_d is sink_ready registered.
  - sink_ready = (count + req_d) ≤ 2, computed from registers only, so the buffer can never overflow.
  - Any sink_valid beat is pushed unconditionally.
- Output path
  - Output fields come from the buffer head or from PAD_VALUE, selected by FSM state.
  - A beat transfers when source_valid && source_ready.
  - Counters: x and y (16 bit); wl and hl hold the latched width and height.
- FSM states
  - IDLE
    - Head with sop: latch width and height into wl and hl, clear x and y, go to ACTIVE. The head is not popped; it becomes the first output beat.
    - If wl or hl is 0: pop the head, pulse err[2], go to DISCARD.
    - Head without sop: pop it, pulse err[2], stay in IDLE.
    - source_valid = 0 in this state.
  - ACTIVE
    - source_valid = buffer not empty. Each transfer pops the head and advances x; at x == wl-1, x returns to 0 and y increments.
    - The final beat (x == wl-1, y == hl-1) drives source_eop=1 and moves to IDLE. If that beat's sink_eop = 0, pulse err[1] and go to DISCARD instead.
    - Head with sink_eop before the final beat: transfer it normally, then go to PAD and pulse err[0].
    - Head with sink_sop at any beat other than the first: do not pop it; go to PAD and pulse err[0].
  - PAD
    - source_valid = 1 with source_data = PAD_VALUE; counters keep advancing.
    - After the final beat, go to IDLE.
    - The buffer is not popped in this state.
  - DISCARD
    - Pop every head beat without emitting it.
    - Head with eop: pop it, go to IDLE.
    - Head with sop: do not pop it, go to IDLE.
- Output markers
  - source_sop = (x==0 && y==0) && source_valid, in ACTIVE and PAD.
  - source_eol = (x==wl-1) && source_valid.
  - Input sop/eop bits never pass through to the output directly.
- Simultaneous events
  - A push and a pop in the same cycle leave count unchanged.
  - A beat carrying both sop and eop is a 1-beat frame. With width=height=1 it passes clean. Otherwise the next frame is padded.

## Timing
- Reset values
  - sink_ready=0 while rst is high, and 1 in the first cycle after release.
  - source_valid, source_sop, source_eop, source_eol = 0; source_data = 0; err = 0.
  - FSM in IDLE; count, x, y, wl, hl = 0.
- Latency
  - A beat pushed in cycle n can appear on the output no earlier than cycle n+1.
  - There is no combinational path from any sink_* input to any source_* output.
- Throughput: one beat per cycle sustained when source_ready is held high.
- Output stability: while source_valid=1 and source_ready=0, all source_* outputs hold stable.
- Reset mid-frame: the buffer is flushed and the counters are cleared. Output resumes only at the next input sop.

## Configuration
- VIDEO_FRAME_ALIGN_XY_EN
  - Defined: adds ports x_pos and y_pos (out, 16 bits each). They carry the coordinates of the current output beat and are valid with source_valid; their reset value is 0.
  - Undefined: these ports and their output logic are absent. The internal counters remain, since frame alignment needs them.

## Test plan
- Clean frame: width=4, height=2, 8 beats with sop on beat 0 and eop on beat 7, source_ready=1 → 8 output beats; sop on beat 0; eol on beats 3 and 7; eop on beat 7; err stays 0.
- Short frame: width=4, height=2, 5 beats with eop on beat 4 → 3 beats of PAD_VALUE follow; eop on beat 7; err[0] pulses once.
- Long frame: width=4, height=2, 11 beats with eop on beat 10 → 8 output beats; eop on beat 7; input beats 8–10 dropped; err[1] pulses once.
- Orphans, then sop: 2 beats without sop, then a clean 4×1 frame → 2 err[2] pulses; 4 output beats with correct sop, eol and eop.
- Backpressure: source_ready toggled 1/0 every cycle during a 4×2 frame → output data is unchanged and in order; sink_ready never lets more than 4 entries be outstanding; no beat is lost.
- Reset mid-frame: rst asserted after 3 of 8 beats, then a fresh clean frame → all outputs 0 during reset; the fresh frame emerges intact starting with sop.
